// File: rtl/seq_bit_run_encoder.sv
// seq_bit_run_encoder
// Turns an accepted single-bit waveform into run-length tokens (bit, length),
// buffers them in a small FIFO and drains them through a val/rdy handshake.
// A run reaching the maximum length is split so the length field never wraps.
module seq_bit_run_encoder #(
    parameter int CNT_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    input  logic             in_bit,
    input  logic             flush,
    output logic             in_rdy,
    output logic             out_val,
    output logic             out_bit,
    output logic [CNT_W-1:0] out_len,
    input  logic             out_rdy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CNT_W-1:0] RUN_MAX   = '1;
    localparam logic [CNT_W-1:0] RUN_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Run tracking state
    state_t           r_state;
    logic             r_run_bit;
    logic [CNT_W-1:0] r_run_len;

    // Token FIFO storage and bookkeeping
    logic             r_mem_bit [FIFO_DEPTH];
    logic [CNT_W-1:0] r_mem_len [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_flush_go;
    logic             w_pop;
    logic             w_push;
    logic             w_push_bit;
    logic [CNT_W-1:0] w_push_len;

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);

    // Flush takes priority over data, so at most one token is closed per cycle.
    assign in_rdy     = reset & ~w_full & ~flush;
    assign w_accept   = in_val & in_rdy;
    assign w_flush_go = flush & reset & ~w_full;

    // The head of the FIFO is presented directly; fields read as zero when empty.
    assign out_val = ~w_empty;
    assign out_bit = w_empty ? 1'b0 : r_mem_bit[r_rd_ptr];
    assign out_len = w_empty ? '0   : r_mem_len[r_rd_ptr];
    assign w_pop   = out_val & out_rdy;

    // Decide whether this cycle closes a run: bit change, saturation or flush.
    always_comb begin
        w_push     = 1'b0;
        w_push_bit = r_run_bit;
        w_push_len = r_run_len;
        if (r_state == S_RUN) begin
            if (w_accept && ((in_bit != r_run_bit) || (r_run_len == RUN_MAX))) begin
                w_push = 1'b1;
            end else if (w_flush_go) begin
                w_push = 1'b1;
            end
        end
    end

    // Run state machine: start, extend, split or close the current run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_run_bit <= 1'b0;
            r_run_len <= '0;
        end else if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    r_state   <= S_RUN;
                    r_run_bit <= in_bit;
                    r_run_len <= RUN_ONE;
                end
                S_RUN: begin
                    if (in_bit != r_run_bit) begin
                        r_run_bit <= in_bit;
                        r_run_len <= RUN_ONE;
                    end else if (r_run_len == RUN_MAX) begin
                        // Saturated run was just emitted; this bit opens the next segment.
                        r_run_len <= RUN_ONE;
                    end else begin
                        r_run_len <= r_run_len + RUN_ONE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_run_len <= '0;
                end
            endcase
        end else if (w_flush_go && (r_state == S_RUN)) begin
            r_state   <= S_IDLE;
            r_run_len <= '0;
        end
    end

    // Token storage write; contents are only observed through a valid head.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_bit[r_wr_ptr] <= w_push_bit;
            r_mem_len[r_wr_ptr] <= w_push_len;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_bit_run_encoder.sv
// Testbench for seq_bit_run_encoder: directed scenarios followed by a random
// phase, all compared against a token-queue reference model.
module tb_seq_bit_run_encoder;

    localparam int CNT_W      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int MAX        = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_val = 1'b0;
    logic             in_bit = 1'b0;
    logic             flush = 1'b0;
    logic             out_rdy = 1'b0;
    logic             in_rdy;
    logic             out_val;
    logic             out_bit;
    logic [CNT_W-1:0] out_len;

    seq_bit_run_encoder #(
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_bit  (in_bit),
        .flush   (flush),
        .in_rdy  (in_rdy),
        .out_val (out_val),
        .out_bit (out_bit),
        .out_len (out_len),
        .out_rdy (out_rdy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: tokens encoded as bit*2^CNT_W + len.
    int exp_q[$];
    int got_q[$];
    bit m_act;
    bit m_bit;
    int m_n;

    function automatic int tok(input int b, input int len);
        return (b << CNT_W) + len;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_got(input string tag, input int idx, input int expv);
        chk(tag, (got_q.size() > idx) ? got_q[idx] : -1, expv);
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_act = 1'b0;
        m_bit = 1'b0;
        m_n   = 0;
    endtask

    // One clock cycle: apply inputs, check at the falling edge, advance the model.
    task automatic cyc(input logic v, input logic b, input logic f, input logic r);
        bit full;
        bit acc;
        bit pop;
        bit psh;
        int ptok;
        in_val  = v;
        in_bit  = b;
        flush   = f;
        out_rdy = r;
        @(negedge clk);
        full = (exp_q.size() == FIFO_DEPTH);
        chk("in_rdy", in_rdy, (!full && !f));
        chk("out_val", out_val, (exp_q.size() > 0));
        chk("out_bit", out_bit, (exp_q.size() > 0) ? ((exp_q[0] >> CNT_W) & 1) : 0);
        chk("out_len", out_len, (exp_q.size() > 0) ? (exp_q[0] & MAX) : 0);
        if (out_val && r) got_q.push_back(tok(out_bit, out_len));
        acc  = v && !full && !f;
        pop  = (exp_q.size() > 0) && r;
        psh  = 1'b0;
        ptok = 0;
        if (acc) begin
            if (!m_act) begin
                m_act = 1'b1;
                m_bit = b;
                m_n   = 1;
            end else if (b != m_bit) begin
                psh   = 1'b1;
                ptok  = tok(m_bit, m_n);
                m_bit = b;
                m_n   = 1;
            end else if (m_n == MAX) begin
                psh  = 1'b1;
                ptok = tok(m_bit, MAX);
                m_n  = 1;
            end else begin
                m_n++;
            end
        end else if (f && !full && m_act) begin
            psh   = 1'b1;
            ptok  = tok(m_bit, m_n);
            m_act = 1'b0;
            m_n   = 0;
        end
        if (pop) void'(exp_q.pop_front());
        if (psh) exp_q.push_back(ptok);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit basic [6];
        bit bp [5];
        bit rb;
        model_clear();
        basic = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        bp    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk("por_out_val", out_val, 0);
        chk("por_out_bit", out_bit, 0);
        chk("por_out_len", out_len, 0);
        chk("por_in_rdy", in_rdy, 0);
        #2 reset = 1'b1;

        // Asynchronous reset in the middle of a run with buffered tokens
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("pre_rst_out_val", out_val, 1);
        in_val = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_rst_out_val", out_val, 0);
        chk("async_rst_out_len", out_len, 0);
        chk("async_rst_in_rdy", in_rdy, 0);
        @(posedge clk);
        #3 reset = 1'b1;
        model_clear();
        got_q.delete();
        cyc(0, 0, 0, 1);
        chk("post_rst_in_rdy", in_rdy, 1);
        cyc(0, 0, 1, 1);
        repeat (3) cyc(0, 0, 0, 1);
        chk("post_rst_no_token", got_q.size(), 0);

        // Basic encode
        got_q.delete();
        for (int i = 0; i < 6; i++) begin
            cyc(1, basic[i], 0, 1);
            if (i == 3) begin
                chk("basic_lat_val", out_val, 1);
                chk("basic_lat_bit", out_bit, 0);
                chk("basic_lat_len", out_len, 3);
            end
        end
        cyc(0, 0, 1, 1);
        repeat (3) cyc(0, 0, 0, 1);
        chk_got("basic_tok0", 0, tok(0, 3));
        chk_got("basic_tok1", 1, tok(1, 2));
        chk_got("basic_tok2", 2, tok(0, 1));
        chk("basic_count", got_q.size(), 3);

        // Saturation at MAX
        got_q.delete();
        for (int i = 0; i < 17; i++) begin
            cyc(1, 1, 0, 1);
            if (i == 15) begin
                chk("sat_lat_val", out_val, 1);
                chk("sat_lat_bit", out_bit, 1);
                chk("sat_lat_len", out_len, MAX);
            end
        end
        cyc(0, 0, 1, 1);
        repeat (3) cyc(0, 0, 0, 1);
        chk_got("sat_tok0", 0, tok(1, 15));
        chk_got("sat_tok1", 1, tok(1, 2));
        chk("sat_count", got_q.size(), 2);

        // Backpressure: fill the FIFO, hold the sixth bit, then drain
        got_q.delete();
        for (int i = 0; i < 5; i++) cyc(1, bp[i], 0, 0);
        chk("bp_full_in_rdy", in_rdy, 0);
        chk("bp_full_out_val", out_val, 1);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 1);
        chk("bp_after_pop_in_rdy", in_rdy, 1);
        cyc(1, 1, 0, 1);
        repeat (5) cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 1);
        repeat (3) cyc(0, 0, 0, 1);
        chk_got("bp_tok0", 0, tok(0, 1));
        chk_got("bp_tok1", 1, tok(1, 1));
        chk_got("bp_tok2", 2, tok(0, 1));
        chk_got("bp_tok3", 3, tok(1, 1));
        chk_got("bp_tok4", 4, tok(0, 1));
        chk_got("bp_tok5", 5, tok(1, 1));

        // Flush corner cases
        got_q.delete();
        cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 1);
        chk("idle_flush_no_token", got_q.size(), 0);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(1, 1, 1, 1);
        chk("flush_tok_val", out_val, 1);
        chk("flush_tok_bit", out_bit, 0);
        chk("flush_tok_len", out_len, 2);
        cyc(1, 1, 0, 1);
        cyc(0, 0, 1, 1);
        repeat (3) cyc(0, 0, 0, 1);
        chk_got("flush_tok0", 0, tok(0, 2));
        chk_got("flush_tok1", 1, tok(1, 1));
        chk("flush_count", got_q.size(), 2);

        // Simultaneous push and pop with three tokens buffered
        got_q.delete();
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        chk("pp_head_bit_before", out_bit, 0);
        cyc(1, 0, 0, 1);
        chk("pp_head_bit_after", out_bit, 1);
        chk("pp_in_rdy", in_rdy, 1);
        repeat (4) cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 1);
        repeat (3) cyc(0, 0, 0, 1);
        chk_got("pp_tok0", 0, tok(0, 1));
        chk_got("pp_tok1", 1, tok(1, 1));
        chk_got("pp_tok2", 2, tok(0, 1));
        chk_got("pp_tok3", 3, tok(1, 1));
        chk_got("pp_tok4", 4, tok(0, 1));

        // Randomized traffic against the reference model
        rb = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) rb = ~rb;
            cyc(($urandom_range(0, 3) != 0), rb, ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 9) < 6));
        end
        cyc(0, 0, 1, 1);
        repeat (8) cyc(0, 0, 0, 1);
        chk("final_empty", out_val, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
